// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Front-end controller for the shared multi-cycle MUL/DIV unit in the EX stage.
//   Takes one M-extension op at a time over valid/ready, issues it to the unit,
//   and holds the result with its destination tag until the pipeline takes it.
//   A pipeline flush kills the in-flight op. If the unit is mid-calculation, the
//   controller drains the unit's result and discards it. An identical repeat op
//   (same op, a and b) is answered from a one-entry result cache without
//   starting the unit.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake; req_op/req_a/req_b/req_tag payload
//   rsp_valid/rsp_ready   response handshake; rsp_data/rsp_tag payload
//   flush                 kill the in-flight op
//   busy                  controller not idle
//   timeout_err           sticky: unit did not answer within TIMEOUT cycles
//   mdu_start/op/a/b      drive the unit (start is a one-cycle pulse)
//   mdu_result/ready/busy from the unit (ready is a one-cycle pulse)
module muldiv_sequencer #(
  parameter int OP_W         = 32,
  parameter int TAG_W        = 5,
  parameter bit ENABLE_REUSE = 1'b1,
  parameter int TIMEOUT      = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OP_W-1:0]  req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [TAG_W-1:0] rsp_tag,
  input  logic             flush,
  output logic             busy,
  output logic             timeout_err,
  output logic             mdu_start,
  output logic [OP_W-1:0]  mdu_op,
  output logic [31:0]      mdu_a,
  output logic [31:0]      mdu_b,
  input  logic [31:0]      mdu_result,
  input  logic             mdu_ready,
  input  logic             mdu_busy
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_e;

  state_e             state_q;
  logic               rsp_valid_q;
  logic [31:0]        rsp_data_q;
  logic [TAG_W-1:0]   rsp_tag_q;
  logic               busy_q;
  logic               timeout_err_q;
  logic               mdu_start_q;
  logic [OP_W-1:0]    mdu_op_q;
  logic [31:0]        mdu_a_q;
  logic [31:0]        mdu_b_q;
  logic [CNT_W-1:0]   tmo_cnt_q;

  // One-entry cache of the last result the unit returned.
  logic               reuse_valid_q;
  logic [OP_W-1:0]    reuse_op_q;
  logic [31:0]        reuse_a_q;
  logic [31:0]        reuse_b_q;
  logic [31:0]        reuse_data_q;

  logic accept;
  logic reuse_hit;
  logic in_wait_region;

  // The unit's busy flag is status only; the ready pulse alone drives the FSM.
  logic unused_mdu_busy;
  assign unused_mdu_busy = mdu_busy;

  // rst_n is included so that req_ready reads 0 while reset is held.
  assign req_ready = rst_n & (state_q == S_IDLE) & ~flush;
  assign accept    = req_valid & req_ready;
  assign reuse_hit = ENABLE_REUSE & reuse_valid_q & (req_op == reuse_op_q) &
                     (req_a == reuse_a_q) & (req_b == reuse_b_q);
  assign in_wait_region = (state_q == S_WAIT) || (state_q == S_DRAIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_tag_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      mdu_start_q   <= 1'b0;
      mdu_op_q      <= '0;
      mdu_a_q       <= '0;
      mdu_b_q       <= '0;
      tmo_cnt_q     <= '0;
      reuse_valid_q <= 1'b0;
      reuse_op_q    <= '0;
      reuse_a_q     <= '0;
      reuse_b_q     <= '0;
      reuse_data_q  <= '0;
    end else begin
      mdu_start_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (accept) begin
            // The operand registers double as the latched request; they stay
            // stable until the unit answers.
            mdu_op_q  <= req_op;
            mdu_a_q   <= req_a;
            mdu_b_q   <= req_b;
            rsp_tag_q <= req_tag;
            busy_q    <= 1'b1;
            if (reuse_hit) begin
              rsp_data_q  <= reuse_data_q;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end else begin
              mdu_start_q <= 1'b1;
              state_q     <= S_ISSUE;
            end
          end
        end

        // The start pulse is already on the wire this cycle, so a flush here
        // still has to drain the unit.
        S_ISSUE: begin
          state_q <= flush ? S_DRAIN : S_WAIT;
        end

        S_WAIT: begin
          if (mdu_ready) begin
            if (flush) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              rsp_data_q    <= mdu_result;
              rsp_valid_q   <= 1'b1;
              reuse_valid_q <= 1'b1;
              reuse_op_q    <= mdu_op_q;
              reuse_a_q     <= mdu_a_q;
              reuse_b_q     <= mdu_b_q;
              reuse_data_q  <= mdu_result;
              state_q       <= S_RESP;
            end
          end else if (flush) begin
            state_q <= S_DRAIN;
          end
        end

        S_RESP: begin
          if (rsp_ready || flush) begin
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        S_DRAIN: begin
          if (mdu_ready) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end

        default: begin
          state_q     <= S_IDLE;
          rsp_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase

      // The timeout counter runs through WAIT and DRAIN (a flush in WAIT does
      // not restart it). It saturates and latches timeout_err; the FSM keeps
      // waiting.
      if (in_wait_region && !mdu_ready) begin
        if (tmo_cnt_q != CNT_MAX) begin
          tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
          if (tmo_cnt_q == CNT_MAX - CNT_W'(1)) begin
            timeout_err_q <= 1'b1;
          end
        end
      end else begin
        tmo_cnt_q <= '0;
      end
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;
  assign mdu_start   = mdu_start_q;
  assign mdu_op      = mdu_op_q;
  assign mdu_a       = mdu_a_q;
  assign mdu_b       = mdu_b_q;

endmodule
